// File: rtl/multicycle_main_fsm.sv
// Multicycle MIPS main control FSM.
// Sequences one instruction through FETCH/DECODE and the per-class execute
// states. It drives every datapath enable and mux select, waits on the memory
// handshake, and flags unsupported opcodes. It also counts retired instructions.
module multicycle_main_fsm #(
  parameter logic [5:0] OP_RTYPE    = 6'b000000,
  parameter logic [5:0] OP_LW       = 6'b100011,
  parameter logic [5:0] OP_SW       = 6'b101011,
  parameter logic [5:0] OP_BEQ      = 6'b000100,
  parameter logic [5:0] OP_ADDI     = 6'b001000,
  parameter logic [5:0] OP_J        = 6'b000010,
  parameter logic       ENABLE_ADDI = 1'b1,
  parameter logic       ENABLE_J    = 1'b1,
  parameter int         CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_src,
  output logic                 pc_write,
  output logic                 branch,
  output logic                 illegal_op,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  // State codes are visible on the debug port, so the encoding is fixed.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // ALU source B selects.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // ALU operation selects.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source selects.
  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t state_reg;
  state_t state_next;
  logic [CNT_WIDTH-1:0] count_reg;
  logic retire;

  // Opcode classification. Optional instructions are gated by their enables,
  // so a disabled opcode falls through to the illegal path.
  logic is_mem;
  logic is_rtype;
  logic is_beq;
  logic is_addi;
  logic is_j;

  assign is_mem   = (op == OP_LW) || (op == OP_SW);
  assign is_rtype = (op == OP_RTYPE);
  assign is_beq   = (op == OP_BEQ);
  assign is_addi  = (op == OP_ADDI) && ENABLE_ADDI;
  assign is_j     = (op == OP_J) && ENABLE_J;

  assign state       = state_reg;
  assign instr_count = count_reg;

  // State register and retired-instruction counter. Reset wins over retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        count_reg <= count_reg + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state, control outputs and retire strobe, decoded from the current state.
  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALURES;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // Read the instruction at PC and compute PC+4 in the same cycle.
        // IR and PC load only when memory delivers the word.
        alu_src_b  = SRCB_FOUR;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is examined.
        alu_src_b = SRCB_BOFF;
        if (is_mem) begin
          state_next = S_MEMADR;
        end else if (is_rtype) begin
          state_next = S_EXECUTE;
        end else if (is_beq) begin
          state_next = S_BRANCH;
        end else if (is_addi) begin
          state_next = S_ADDIEXEC;
        end else if (is_j) begin
          state_next = S_JUMP;
        end else begin
          illegal_op = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_mask_free_wb: begin
        end
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        // The write strobe is held for the whole wait; the store retires
        // only on the cycle memory accepts it.
        iord       = 1'b1;
        mem_write  = 1'b1;
        retire     = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        // The datapath qualifies branch with the ALU zero flag.
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_ALUOUT;
        branch     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        // Unreachable codes recover to FETCH with every enable low.
        state_next = S_FETCH;
      end
    endcase

    // While reset is held, present the FETCH selects with every enable
    // low, so nothing in the datapath or memory is disturbed.
    if (reset) begin
      retire     = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_FOUR;
      alu_op     = ALU_ADD;
      pc_src     = PC_ALURES;
      pc_write   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
